// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
// Picks one DMA channel from the hardware DREQ pins and the software request
// register, runs the HRQ/HLDA hold handshake with the CPU, and presents the
// granted channel to timing control until the transfer cycle completes.

module dma_priority_arbiter #(
   parameter int NUM_CH = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic              dreqActiveLow,
   input  logic              rotatingPriority,
   input  logic              ctrlDisable,
   input  logic [NUM_CH-1:0] maskReg,
   input  logic [NUM_CH-1:0] requestReg,
   input  logic              HLDA,
   input  logic              cycleDone,
   input  logic              EOP_N,
   output logic              hrq,
   output logic [NUM_CH-1:0] VALID_DREQ,
   output logic [NUM_CH-1:0] dack,
   output logic [1:0]        activeCh,
   output logic [NUM_CH-1:0] clrSwReq,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SVC  = 2'd2,
      DONE = 2'd3
   } arbStateT;

   arbStateT          state;
   logic [NUM_CH-1:0] dreqS;
   logic [NUM_CH-1:0] pending;
   logic [1:0]        prioPtr;
   logic [1:0]        searchBase;
   logic [1:0]        cand;
   logic [1:0]        winCh;
   logic              winValid;

   function automatic logic [NUM_CH-1:0] oneHot(input logic [1:0] ch);
      logic [NUM_CH-1:0] v;
      v     = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

   // Register the raw DREQ pins; the reset value reads as "not requesting"
   // in either pin polarity so nothing is seen in the first cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         dreqS <= {NUM_CH{dreqActiveLow}};
      end else begin
         dreqS <= DREQ;
      end
   end

   // Combine polarity-corrected, masked hardware requests with software requests.
   always_comb begin
      pending = ((dreqS ^ {NUM_CH{dreqActiveLow}}) & ~maskReg) | requestReg;
   end

   // Find the first pending channel, starting at channel 0 in fixed mode or at
   // prioPtr in rotating mode, wrapping from channel 3 back to channel 0.
   always_comb begin
      winCh      = 2'd0;
      winValid   = 1'b0;
      cand       = 2'd0;
      searchBase = rotatingPriority ? prioPtr : 2'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = searchBase + 2'(i);
         if (!winValid && pending[cand]) begin
            winCh    = cand;
            winValid = 1'b1;
         end
      end
   end

   // Grant sequencer: IDLE -> REQ (hold request) -> SVC (acknowledged, transfer
   // running) -> DONE (one cycle of cleanup) -> IDLE. The grant latched on
   // leaving IDLE stays fixed until DONE, so late or higher-priority requests
   // cannot preempt it. prioPtr only moves in rotating mode and is otherwise held.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         prioPtr    <= 2'd0;
         hrq        <= 1'b0;
         dack       <= '0;
         VALID_DREQ <= '0;
         clrSwReq   <= '0;
         busy       <= 1'b0;
         activeCh   <= 2'd0;
      end else begin
         clrSwReq <= '0;
         case (state)
            IDLE: begin
               if (winValid && !ctrlDisable && !HLDA) begin
                  activeCh <= winCh;
                  hrq      <= 1'b1;
                  busy     <= 1'b1;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (HLDA) begin
                  dack       <= oneHot(activeCh);
                  VALID_DREQ <= oneHot(activeCh);
                  state      <= SVC;
               end
            end
            SVC: begin
               if (cycleDone || !EOP_N || !HLDA) begin
                  state <= DONE;
               end
            end
            DONE: begin
               hrq        <= 1'b0;
               dack       <= '0;
               VALID_DREQ <= '0;
               busy       <= 1'b0;
               clrSwReq   <= oneHot(activeCh) & requestReg;
               if (rotatingPriority) begin
                  prioPtr <= activeCh + 2'd1;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
